// File: rtl/commit_unit_pkg.sv
// Shared definitions for the in-order retirement back end: window geometry,
// instruction type encodings and the commit/flush/recover state type.
package commit_unit_pkg;

  localparam int NUM_RET   = 3;
  localparam int ARCH_REGS = 8;
  localparam int PREG_W    = 5;
  localparam int RW_W      = $clog2(ARCH_REGS);
  localparam int SLOT_W    = $clog2(NUM_RET);

  localparam logic [1:0] TYPE_NODEST = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } commit_state_t;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/commit_unit_mask_gen.sv
// Combinational retire-window decode: which head slots commit in order, and
// whether the first non-committing slot is a ready, excepting instruction.
module commit_mask_gen
  import commit_unit_pkg::*;
(
  input  logic [NUM_RET-1:0] ready_ret,
  input  logic [NUM_RET-1:0] excep_ret,
  output logic [NUM_RET-1:0] commit_mask,
  output logic               excep_valid,
  output logic [SLOT_W-1:0]  excep_slot
);

  logic still_in_order;

  // Walk oldest to youngest; the first slot that cannot commit stops the
  // window, and it raises an exception event only if it is ready.
  always_comb begin
    commit_mask    = '0;
    excep_valid    = 1'b0;
    excep_slot     = '0;
    still_in_order = 1'b1;
    for (int i = 0; i < NUM_RET; i++) begin
      if (still_in_order) begin
        if (ready_ret[i] && !excep_ret[i]) begin
          commit_mask[i] = 1'b1;
        end else begin
          still_in_order = 1'b0;
          if (ready_ret[i] && excep_ret[i]) begin
            excep_valid = 1'b1;
            excep_slot  = SLOT_W'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/commit_unit.sv
// Retirement back end: commits head slots, maintains the architectural map,
// frees superseded physical registers and sequences flush/recover on faults.
module commit_unit
  import commit_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RET-1:0]   ready_ret,
  input  logic [NUM_RET-1:0]   excep_ret,
  input  logic [1:0]           Type_ret   [NUM_RET],
  input  logic [PREG_W-1:0]    Pw_ret     [NUM_RET],
  input  logic [PREG_W-1:0]    Pw_old_ret [NUM_RET],
  input  logic [RW_W-1:0]      Rw_ret     [NUM_RET],
  output logic [NUM_RET-1:0]   commit_mask,
  output logic [NUM_RET-1:0]   free_valid,
  output logic [PREG_W-1:0]    free_Pw    [NUM_RET],
  output logic [PREG_W-1:0]    arch_map   [ARCH_REGS],
  output logic                 flush,
  output logic                 recover_valid,
  output logic [15:0]          commit_cnt,
  output logic [7:0]           excep_cnt
);

  commit_state_t      state;
  logic [NUM_RET-1:0] mask_c;
  logic               excep_valid_c;
  logic [SLOT_W-1:0]  excep_slot_c;
  logic [15:0]        commit_inc;

  commit_mask_gen u_mask_gen (
    .ready_ret   (ready_ret),
    .excep_ret   (excep_ret),
    .commit_mask (mask_c),
    .excep_valid (excep_valid_c),
    .excep_slot  (excep_slot_c)
  );

  // On an exception the number of committing slots equals the faulting index.
  assign commit_inc = excep_valid_c ? 16'(excep_slot_c) : 16'(popcount3(mask_c));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      commit_mask   <= '0;
      free_valid    <= '0;
      flush         <= 1'b0;
      recover_valid <= 1'b0;
      commit_cnt    <= '0;
      excep_cnt     <= '0;
      for (int i = 0; i < NUM_RET; i++) free_Pw[i] <= '0;
      for (int r = 0; r < ARCH_REGS; r++) arch_map[r] <= PREG_W'(r);
    end else begin
      commit_mask   <= '0;
      free_valid    <= '0;
      flush         <= 1'b0;
      recover_valid <= 1'b0;
      for (int i = 0; i < NUM_RET; i++) free_Pw[i] <= '0;

      case (state)
        IDLE: begin
          commit_mask <= mask_c;
          // Ascending slot order so the youngest writer of a register wins.
          for (int i = 0; i < NUM_RET; i++) begin
            if (mask_c[i] && (Type_ret[i] != TYPE_NODEST)) begin
              arch_map[Rw_ret[i]] <= Pw_ret[i];
              free_valid[i]       <= 1'b1;
              free_Pw[i]          <= Pw_old_ret[i];
            end
          end
          commit_cnt <= commit_cnt + commit_inc;
          if (excep_valid_c) begin
            state <= FLUSH;
            flush <= 1'b1;
            if (excep_cnt != 8'hFF) excep_cnt <= excep_cnt + 8'd1;
          end
        end
        FLUSH: begin
          state         <= RECOVER;
          recover_valid <= 1'b1;
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
